gpio_pio_debounced: RTL
=======================

# gpio_pio_debounced

Parametrised Avalon-MM general-purpose I/O port. It is the next-generation PIO for the Computer_System Qsys fabric and keeps the existing DATA/DIR/MASK/CAPTURE register layout. It adds per-bit input debouncing, per-bit rising/falling edge selection, atomic output set/clear, and no-lost-edge capture semantics. It sits between an Avalon slave port on the system interconnect and board pins, such as a GPIO header or keys.

## Interface
- `WIDTH`, 32: number of I/O bits, legal range 1..32.
- `DB_CYCLES`, 16: clock cycles an input must hold a new value before it is accepted. 0 bypasses the debouncer.
- `RESET_OUT`, 0: reset value of the output data register.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset. All state clears on assertion.
- `address`  in  3: word register select.
- `chipselect`  in  1: slave select.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  32: write data. Bits [31:WIDTH] are ignored.
- `readdata`  out  32: registered read data. Bits [31:WIDTH] read 0. Reset value is 0.
- `irq`  out  1: level interrupt, equal to `|(capture & mask)`. Reset value is 0.
- `bidir_port`  inout  WIDTH: pins. Bit i is driven with `data_out[i]` when `dir[i]`=1, otherwise high-Z. Reset state is high-Z.

## Operation
- Register map, where wr = `chipselect & ~write_n`:
  - 0 DATA: read returns the debounced input `stable`; write sets `data_out`.
  - 1 DIR: read/write; 1 = output.
  - 2 MASK: read/write IRQ mask.
  - 3 CAPTURE: read returns capture bits; writing 1 to a bit clears it.
  - 4 RISE_EN: read/write.
  - 5 FALL_EN: read/write.
  - 6 OUTSET: write performs `data_out |= wd`; read returns `data_out`.
  - 7 OUTCLR: write performs `data_out &= ~wd`; read returns `data_out`.
- Reset values: `data_out`=RESET_OUT, DIR=0, MASK=0, CAPTURE=0, RISE_EN=all ones, FALL_EN=0, sync stages=0, `stable`=0, counters=0.
- Input path, per bit:
  - The pin passes through a 2-flop synchroniser (sync1, sync2).
  - The pin value is sampled regardless of DIR, so driven outputs read back.
- Debounce, per bit, when DB_CYCLES>0:
  - If sync2 ≠ `stable`: when cnt = DB_CYCLES−1, `stable` ← sync2 and cnt ← 0; otherwise cnt ← cnt+1.
  - If sync2 = `stable`: cnt ← 0. Any glitch back to the old value therefore restarts the count.
  - Counter width is `$clog2(DB_CYCLES+1)`.
- Debounce bypass, when DB_CYCLES=0: `stable` is sync2, combinationally. No counter is built.
- Edge detect:
  - A `stable_d` register holds the previous `stable`.
  - rise = `stable & ~stable_d`; fall = `~stable & stable_d`.
  - event = `(rise & RISE_EN) | (fall & FALL_EN)`.
  - Setting both enables for a bit captures both edges.
- Capture, per bit:
  - event sets the bit; a CAPTURE write of 1 clears it.
  - If set and clear occur in the same cycle, set wins, so no edge is lost.
- Inputs held high through reset release produce a rising edge after the normal latency. This is intended.

## Timing
- Pin change settles before clock edge k. sync1 updates at k and sync2 at k+1.
- `stable` updates at edge k+1+DB_CYCLES. With DB_CYCLES=0 this is k+1.
- A capture bit and `irq` assert after edge k+2+DB_CYCLES.
- `readdata` is registered every cycle from the current `address`. It is valid one clock after `address` is presented (read latency 1, no wait-states).
- Register writes take effect at the clock edge that samples wr. Pin drive changes at the same edge, since it is combinational from `dir`/`data_out`.
- Reset mid-debounce discards the partial count and `stable`. After release, a full DB_CYCLES qualification is needed again.

## Structure
- Shared package `gpio_pio_pkg` holds the register offset constants (ADDR_DATA..ADDR_OUTCLR) and the counter-width function.
- One sub-module, `gpio_debounce`: a WIDTH-bit synchroniser plus per-bit debounce counters and `stable` output, with the DB_CYCLES parameter.
- The top level contains the register file, edge logic, read mux and tristates.

## Test plan
1. Reset with WIDTH=8 → `readdata`=0, `irq`=0, all pins Z; reading RISE_EN returns 0xFF and OUTSET returns RESET_OUT.
2. DB_CYCLES=4, bit0 pin pulsed high for 3 clocks → DATA stays 0 and CAPTURE stays 0. Bit0 held high from edge k → DATA bit0=1 after edge k+5, CAPTURE=0x01 after edge k+6.
3. FALL_EN=0x08, RISE_EN=0, MASK=0x08:
   - Bit3 rises → no capture.
   - Bit3 falls → CAPTURE=0x08 and `irq`=1.
   - Write 0x08 to addr 3 → CAPTURE=0 and `irq`=0 the next cycle.
4. CAPTURE bit2 set, then a CAPTURE write of 0x04 coincides with a new bit2 event → CAPTURE bit2 remains 1.
5. DATA=0x0F, DIR=0xFF:
   - Write 0xF0 to addr 6 → `data_out`=0xFF.
   - Write 0x3C to addr 7 → `data_out`=0xC3.
   - Pins show 0xC3 and DATA reads 0xC3 after latency.
6. DB_CYCLES=4, pin high, `reset_n` pulsed low after 2 counted cycles → after release, DATA stays 0 for 5 clocks and becomes 1 only after a full qualification.

Source files
------------

// File: rtl/gpio_pio_pkg.sv
// Shared constants for the debounced PIO: register offsets and debounce counter sizing.
package gpio_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CAPTURE = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd7;

    // Width of a counter that must reach db_cycles; never below 1 so declarations stay legal.
    function automatic int unsigned cnt_width(input int unsigned db_cycles);
        if (db_cycles == 0) begin
            return 1;
        end
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_pio_debounced_if.sv
// Avalon-MM slave bus bundle for the debounced PIO, including the level interrupt.
interface gpio_pio_debounced_if;
    import gpio_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/gpio_debounce.sv
// Per-bit 2-flop synchroniser followed by a hold-time debouncer producing the accepted level.
module gpio_debounce
    import gpio_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] stable_o
);

    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    if (DB_CYCLES == 0) begin : g_bypass
        assign stable_o = sync2_q;
    end else begin : g_db
        localparam int unsigned     CntW   = cnt_width(DB_CYCLES);
        localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

        logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0]           stable_q, stable_d;

        // Any return to the accepted level restarts qualification from zero.
        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (cnt_q[i] == CntMax) begin
                        stable_d[i] = sync2_q[i];
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q    <= '0;
                stable_q <= '0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign stable_o = stable_q;
    end

endmodule

// File: rtl/gpio_pio_debounced.sv
// Avalon-MM GPIO port: register file, edge capture with set-wins clear, read mux and pin tristates.
module gpio_pio_debounced
    import gpio_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DB_CYCLES = 16,
    parameter logic [31:0] RESET_OUT = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    gpio_pio_debounced_if.slave bus,
    inout  wire [WIDTH-1:0]  bidir_port
);

    typedef logic [WIDTH-1:0] word_t;

    word_t data_out_q, data_out_d;
    word_t dir_q, dir_d;
    word_t mask_q, mask_d;
    word_t capture_q, capture_d;
    word_t rise_en_q, rise_en_d;
    word_t fall_en_q, fall_en_d;
    word_t stable, stable_prev_q;
    word_t rise, fall, evt, cap_clr, wd;
    logic  wr;

    logic [DATA_W-1:0] readdata_q, readdata_d;

    gpio_debounce #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .pin_i    (bidir_port),
        .stable_o (stable)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
    end

    assign wr   = bus.chipselect & ~bus.write_n;
    assign wd   = bus.writedata[WIDTH-1:0];
    assign rise = stable & ~stable_prev_q;
    assign fall = ~stable & stable_prev_q;
    assign evt  = (rise & rise_en_q) | (fall & fall_en_q);

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        cap_clr    = '0;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:    data_out_d = wd;
                ADDR_DIR:     dir_d      = wd;
                ADDR_MASK:    mask_d     = wd;
                ADDR_CAPTURE: cap_clr    = wd;
                ADDR_RISE_EN: rise_en_d  = wd;
                ADDR_FALL_EN: fall_en_d  = wd;
                ADDR_OUTSET:  data_out_d = data_out_q | wd;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
                default:      ;
            endcase
        end
        // A new event in the same cycle as a clear keeps the bit set.
        capture_d = (capture_q & ~cap_clr) | evt;
    end

    always_comb begin
        readdata_d = '0;
        unique case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
            ADDR_DIR:     readdata_d[WIDTH-1:0] = dir_q;
            ADDR_MASK:    readdata_d[WIDTH-1:0] = mask_q;
            ADDR_CAPTURE: readdata_d[WIDTH-1:0] = capture_q;
            ADDR_RISE_EN: readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN: readdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_OUTSET:  readdata_d[WIDTH-1:0] = data_out_q;
            ADDR_OUTCLR:  readdata_d[WIDTH-1:0] = data_out_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q    <= RESET_OUT[WIDTH-1:0];
            dir_q         <= '0;
            mask_q        <= '0;
            capture_q     <= '0;
            rise_en_q     <= '1;
            fall_en_q     <= '0;
            stable_prev_q <= '0;
            readdata_q    <= '0;
        end else begin
            data_out_q    <= data_out_d;
            dir_q         <= dir_d;
            mask_q        <= mask_d;
            capture_q     <= capture_d;
            rise_en_q     <= rise_en_d;
            fall_en_q     <= fall_en_d;
            stable_prev_q <= stable;
            readdata_q    <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(capture_q & mask_q);

endmodule
